// File: rtl/counter_16_monitor_pkg.sv
// Shared definitions for the 16-bit cascaded counter monitor: FSM and MODO
// encodings plus the golden next-value / wrap-detect step function.
package counter_16_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } mon_state_t;

    typedef enum logic [1:0] {
        MODO_UP   = 2'b00,
        MODO_DN1  = 2'b01,
        MODO_DN3  = 2'b10,
        MODO_LOAD = 2'b11
    } modo_t;

    localparam int unsigned STEP_W = 32;

    typedef struct packed {
        logic              wrap;
        logic [STEP_W-1:0] nxt;
    } step_t;

    // Values are masked to w bits, so one function serves any WIDTH up to 32.
    function automatic step_t model_step(
        input logic [STEP_W-1:0] m,
        input logic [STEP_W-1:0] d,
        input logic              enb,
        input modo_t             modo,
        input int unsigned       w
    );
        logic [STEP_W-1:0] mask;
        logic [STEP_W-1:0] mm;
        step_t             r;
        mask   = (w >= STEP_W) ? '1 : ((STEP_W'(1) << w) - STEP_W'(1));
        mm     = m & mask;
        r.wrap = 1'b0;
        r.nxt  = '0;
        if (enb) begin
            unique case (modo)
                MODO_UP: begin
                    r.wrap = (mm == mask);
                    r.nxt  = (mm + STEP_W'(1)) & mask;
                end
                MODO_DN1: begin
                    r.wrap = (mm == '0);
                    r.nxt  = (mm - STEP_W'(1)) & mask;
                end
                MODO_DN3: begin
                    r.wrap = (mm < STEP_W'(3));
                    r.nxt  = (mm - STEP_W'(3)) & mask;
                end
                MODO_LOAD: begin
                    r.nxt  = d & mask;
                end
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_16_monitor_model.sv
// Golden count model: the M register, its next-value logic and wrap detect.
module count_model
    import counter_16_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             run,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] m,
    output logic             wrap
);

    step_t step;

    always_comb begin
        step = model_step(STEP_W'(m), STEP_W'(d), enb, modo_t'(modo), WIDTH);
        wrap = run && step.wrap;
    end

    if (WIDTH < STEP_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^step.nxt[STEP_W-1:WIDTH];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m <= '0;
        end else if (load) begin
            m <= load_val;
        end else if (run) begin
            m <= step.nxt[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/counter_16_monitor.sv
// Cycle-accurate checker for the 16-bit cascaded counter: FSM, expected-value
// pipe, comparator and saturating mismatch/wrap counters.
module counter_16_monitor
    import counter_16_monitor_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned LAT         = 1,
    parameter int unsigned CNT_W       = 16,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ARM,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    output logic             CHK_VALID,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] WRAP_CNT,
    output logic [WIDTH-1:0] FIRST_EXP,
    output logic [WIDTH-1:0] FIRST_GOT,
    output logic [1:0]       STATE
);

    mon_state_t       state_q, state_d;
    logic [2:0]       fill_q, fill_d;
    logic             arm_load, run, cmp;
    logic             mismatch, wrap;
    logic [WIDTH-1:0] m, exp_val;

    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q, wrap_cnt_q;
    logic [WIDTH-1:0] first_exp_q, first_got_q;

    count_model #(.WIDTH(WIDTH)) u_model (
        .CLK      (CLK),
        .RST      (RST),
        .load     (arm_load),
        .load_val (Q),
        .run      (run),
        .enb      (ENB),
        .modo     (MODO),
        .d        (D),
        .m        (m),
        .wrap     (wrap)
    );

    // EXP is M delayed by LAT-1 run edges; the pipe is frozen outside SYNC/CHECK.
    if (LAT > 1) begin : g_pipe
        logic [WIDTH-1:0] pipe [LAT-1];
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int unsigned i = 0; i < LAT - 1; i++) pipe[i] <= '0;
            end else if (run) begin
                pipe[0] <= m;
                for (int unsigned i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign exp_val = pipe[LAT-2];
    end else begin : g_nopipe
        assign exp_val = m;
    end

    assign mismatch = (Q != exp_val);

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        arm_load = 1'b0;
        run      = 1'b0;
        cmp      = 1'b0;
        if (!ARM) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SYNC;
                    arm_load = 1'b1;
                    fill_d   = 3'(LAT);
                end
                ST_SYNC: begin
                    run    = 1'b1;
                    fill_d = fill_q - 3'd1;
                    if (fill_q == 3'd1) state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    run = 1'b1;
                    cmp = 1'b1;
                    if (mismatch && STOP_ON_ERR) state_d = ST_HALT;
                end
                ST_HALT: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
        end else if (arm_load) begin
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
        end else begin
            if (cmp && mismatch) begin
                err_q <= 1'b1;
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                if (!err_q) begin
                    first_exp_q <= exp_val;
                    first_got_q <= Q;
                end
            end
            if (wrap && (wrap_cnt_q != '1)) wrap_cnt_q <= wrap_cnt_q + 1'b1;
        end
    end

    assign CHK_VALID = (state_q == ST_CHECK);
    assign ERR       = err_q;
    assign ERR_CNT   = err_cnt_q;
    assign WRAP_CNT  = wrap_cnt_q;
    assign FIRST_EXP = first_exp_q;
    assign FIRST_GOT = first_got_q;
    assign STATE     = state_q;

endmodule
